uart_tx_framed: RTL and testbench



---
 rtl/uart_tx_framed.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_framed.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
// rtl/uart_tx_framed.sv - parametrised framed UART serialiser (start + data + [parity] + stop)
// Optional parity bit: define UART_TX_PARITY_EN (adds parity_odd port and PARITY state).
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   in_valid   producer has a word on in_data
//   in_ready   word accepted on this edge when in_valid is also high (IDLE and not in reset)
//   in_data    DATA_BITS word, bit 0 sent first
//   parity_odd 1 = odd, 0 = even parity, sampled at accept (UART_TX_PARITY_EN only)
//   tx         registered serial line, idle high
//   busy       frame in progress
module uart_tx_framed #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
`ifdef UART_TX_PARITY_EN
   input  logic                 parity_odd,
`endif
   output logic                 tx,
   output logic                 busy
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_framed: DATA_BITS must be in 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_tx_framed: CLKS_PER_BIT must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx_framed: STOP_BITS must be 1 or 2");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t                 state_q, state_d;
   logic [BAUD_W-1:0]      baud_q, baud_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic                   tx_q, tx_d;
   logic                   bit_end;
`ifdef UART_TX_PARITY_EN
   logic                   par_q, par_d;
`endif

   assign in_ready = (state_q == S_IDLE) && !rst;
   assign busy     = (state_q != S_IDLE);
   assign tx       = tx_q;
   assign bit_end  = (baud_q == BAUD_LAST);

   // tx_d is the line level for the state being entered, so tx stays registered
   // and changes on the same edge as the state.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (in_valid && in_ready) begin
               state_d = S_START;
               shreg_d = in_data;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
               // Parity is fixed at accept since the shift register is consumed.
               par_d   = (^in_data) ^ parity_odd;
`endif
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               tx_d    = shreg_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
                  tx_d    = par_q;
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shreg_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            tx_d = 1'b1;
            // bit counter is reused to count stop bits
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_framed.sv
// tb/tb_uart_tx_framed.sv - scoreboard bench for uart_tx_framed (8/4/1 and 9/3/2 instances)
module tb_uart_tx_framed;

   localparam int CPB_A = 4;
   localparam int CPB_B = 3;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int F_A = (1 + 8 + P + 1) * CPB_A;
   localparam int F_B = (1 + 9 + P + 2) * CPB_B;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid_a, in_ready_a, tx_a, busy_a;
   logic [7:0] in_data_a;
   logic       in_valid_b, in_ready_b, tx_b, busy_b;
   logic [8:0] in_data_b;
`ifdef UART_TX_PARITY_EN
   logic       parity_odd_a, parity_odd_b;
`endif

   int cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int          start;
      int          n;
      logic [15:0] lv;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_framed #(.DATA_BITS(8), .CLKS_PER_BIT(CPB_A), .STOP_BITS(1)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_a),
      .in_ready   (in_ready_a),
      .in_data    (in_data_a),
`ifdef UART_TX_PARITY_EN
      .parity_odd (parity_odd_a),
`endif
      .tx         (tx_a),
      .busy       (busy_a)
   );

   uart_tx_framed #(.DATA_BITS(9), .CLKS_PER_BIT(CPB_B), .STOP_BITS(2)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid_b),
      .in_ready   (in_ready_b),
      .in_data    (in_data_b),
`ifdef UART_TX_PARITY_EN
      .parity_odd (parity_odd_b),
`endif
      .tx         (tx_b),
      .busy       (busy_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Line levels per bit period: start, data LSB first, optional parity, stop bits.
   function automatic exp_t mk(input int start, input logic [8:0] d, input int db,
                               input logic has_par, input logic pbit, input int ns);
      exp_t e;
      int   k;
      e.start = start;
      e.lv    = '0;
      k       = 1;
      for (int i = 0; i < db; i++) begin
         e.lv[k] = d[i];
         k++;
      end
      if (has_par) begin
         e.lv[k] = pbit;
         k++;
      end
      for (int i = 0; i < ns; i++) begin
         e.lv[k] = 1'b1;
         k++;
      end
      e.n = k;
      return e;
   endfunction

   function automatic logic mon_tx(input int s);
      return (s == 0) ? tx_a : tx_b;
   endfunction
   function automatic logic mon_busy(input int s);
      return (s == 0) ? busy_a : busy_b;
   endfunction
   function automatic logic mon_rdy(input int s);
      return (s == 0) ? in_ready_a : in_ready_b;
   endfunction

   task automatic monitor(input int s);
      exp_t e;
      int   cpb;
      int   pending;
      logic act_lv;
      logic ok_busy;
      cpb = (s == 0) ? CPB_A : CPB_B;
      forever begin
         @(negedge clk);
         pending = (s == 0) ? q_a.size() : q_b.size();
         if (pending > 0 && mon_tx(s) == 1'b0) begin
            if (s == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            chk($sformatf("dut%0d start_cycle", s), e.start == cyc ? e.start : cyc, e.start);
            ok_busy = 1'b1;
            for (int p = 0; p < e.n; p++) begin
               act_lv = e.lv[p];
               for (int c = 0; c < cpb; c++) begin
                  if (p != 0 || c != 0) @(negedge clk);
                  if (mon_tx(s) !== e.lv[p]) act_lv = mon_tx(s);
                  if (mon_busy(s) !== 1'b1 || mon_rdy(s) !== 1'b0) ok_busy = 1'b0;
               end
               chk($sformatf("dut%0d frame@%0d period%0d tx", s, e.start, p), act_lv, e.lv[p]);
            end
            chk($sformatf("dut%0d frame@%0d busy_hi_ready_lo", s, e.start), ok_busy, 1);
            @(negedge clk);
            chk($sformatf("dut%0d frame@%0d idle {tx,rdy,busy}", s, e.start),
                {mon_tx(s), mon_rdy(s), mon_busy(s)}, 3'b110);
         end
      end
   endtask

   task automatic send_a(input logic [7:0] d, input logic po, input logic pb);
      q_a.push_back(mk(cyc + 1, {1'b0, d}, 8, P == 1, pb, 1));
      in_valid_a = 1'b1;
      in_data_a  = d;
`ifdef UART_TX_PARITY_EN
      parity_odd_a = po;
`endif
      @(negedge clk);
      in_valid_a = 1'b0;
      in_data_a  = ~d;
`ifdef UART_TX_PARITY_EN
      parity_odd_a = ~po;
`endif
      repeat (F_A) @(negedge clk);
   endtask

   task automatic send_b(input logic [8:0] d, input logic po, input logic pb);
      q_b.push_back(mk(cyc + 1, d, 9, P == 1, pb, 2));
      in_valid_b = 1'b1;
      in_data_b  = d;
`ifdef UART_TX_PARITY_EN
      parity_odd_b = po;
`endif
      @(negedge clk);
      in_valid_b = 1'b0;
      in_data_b  = ~d;
`ifdef UART_TX_PARITY_EN
      parity_odd_b = ~po;
`endif
      repeat (F_B) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      in_valid_a = 1'b0;
      in_data_a  = '0;
      in_valid_b = 1'b0;
      in_data_b  = '0;
`ifdef UART_TX_PARITY_EN
      parity_odd_a = 1'b0;
      parity_odd_b = 1'b0;
`endif
      fork
         monitor(0);
         monitor(1);
      join_none

      // Reset: outputs idle, in_ready low while rst is high; in_valid during reset is ignored.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst tx_a", tx_a, 1);
         chk("rst busy_a", busy_a, 0);
         chk("rst in_ready_a", in_ready_a, 0);
         chk("rst tx_b", tx_b, 1);
         chk("rst busy_b", busy_b, 0);
         if (i == 2) begin
            in_valid_a = 1'b1;
            in_valid_b = 1'b1;
            in_data_a  = 8'h00;
         end
      end
      @(negedge clk);
      rst        = 1'b0;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      #1;
      chk("post_rst {tx,rdy,busy}_a", {tx_a, in_ready_a, busy_a}, 3'b110);
      chk("post_rst {tx,rdy,busy}_b", {tx_b, in_ready_b, busy_b}, 3'b110);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_accept_in_reset a", {tx_a, busy_a}, 2'b10);
         chk("no_accept_in_reset b", {tx_b, busy_b}, 2'b10);
      end

      // Single frame 8'hA5: data 1,0,1,0,0,1,0,1; even parity 0.
      send_a(8'hA5, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // Back-to-back with in_valid held: 8'h00 then 8'hFF, second start F_A+1 later.
      q_a.push_back(mk(cyc + 1, 9'h000, 8, P == 1, 1'b0, 1));
      q_a.push_back(mk(cyc + 1 + F_A + 1, 9'h0FF, 8, P == 1, 1'b0, 1));
      in_valid_a = 1'b1;
      in_data_a  = 8'h00;
      @(negedge clk);
      in_data_a  = 8'hFF;
      repeat (F_A) @(negedge clk);
      @(negedge clk);
      in_valid_a = 1'b0;
      in_data_a  = 8'h12;
      repeat (F_A) @(negedge clk);
      repeat (2) @(negedge clk);

`ifdef UART_TX_PARITY_EN
      // 8'h07 has three ones: even parity bit 1, odd parity bit 0.
      send_a(8'h07, 1'b0, 1'b1);
      send_a(8'h07, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
`endif

      // Reset during data bit 3 of 8'h3C (bit 3 spans start+16 .. start+19).
      in_valid_a = 1'b1;
      in_data_a  = 8'h3C;
      @(negedge clk);
      in_valid_a = 1'b0;
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_frame_rst {tx,rdy,busy}", {tx_a, in_ready_a, busy_a}, 3'b110);
      // 8'hC3 has four ones: even parity 0.
      send_a(8'hC3, 1'b0, 1'b0);
      repeat (2) @(negedge clk);

      // 9-bit, 3 clocks/bit, 2 stop bits: 9'h101 -> 1,0,0,0,0,0,0,0,1; even parity 0.
      send_b(9'h101, 1'b0, 1'b0);
      repeat (3) @(negedge clk);

      chk("scoreboard_a drained", q_a.size(), 0);
      chk("scoreboard_b drained", q_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
